qaoa_kernel_udiv_141ns_53ns: RTL

QAOA_KERNEL_UDIV_141NS_53NS -- requirements
Module: qaoa_kernel_udiv_141ns_53ns

---
 rtl/qaoa_kernel_div_pkg.sv | 29 ++
 rtl/qaoa_kernel_div_step.sv | 40 ++++
 rtl/qaoa_kernel_udiv_141ns_53ns.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/qaoa_kernel_div_pkg.sv
// -----------------------------------------------------------------------------
// qaoa_kernel_div_pkg
//
// Shared definitions for the QAOA kernel unsigned divider:
//   - default operand widths (141-bit dividend, 53-bit divisor, 90-bit quotient)
//   - step-counter width helper ($clog2(QUOT_W+1))
//   - FSM state encoding used by the divider top level
// -----------------------------------------------------------------------------
package qaoa_kernel_div_pkg;

    localparam int DEF_DIVIDEND_W = 141;
    localparam int DEF_DIVISOR_W  = 53;
    localparam int DEF_QUOT_W     = 90;

    // Width of a counter that can hold 0..quot_w inclusive.
    function automatic int cnt_width(input int quot_w);
        return $clog2(quot_w + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_QUOT_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ITER  = 2'd2,
        ST_DONE  = 2'd3
    } div_state_e;

endpackage : qaoa_kernel_div_pkg

// File: rtl/qaoa_kernel_div_step.sv
// -----------------------------------------------------------------------------
// qaoa_kernel_div_step
//
// One radix-2 restoring division step (purely combinational).
// The incoming partial remainder is shifted left by one, the next dividend bit
// enters at the LSB, and the divisor is subtracted when it fits.
//
// Ports:
//   i_rem      [DIVISOR_W-1:0]  current partial remainder (always < divisor)
//   i_bit                       next dividend bit, MSB-first
//   i_divisor  [DIVISOR_W-1:0]  divisor
//   o_rem      [DIVISOR_W-1:0]  new partial remainder
//   o_qbit                      quotient bit produced by this step
// -----------------------------------------------------------------------------
module qaoa_kernel_div_step #(
    parameter int DIVISOR_W = 53
) (
    input  logic [DIVISOR_W-1:0] i_rem,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W-1:0] o_rem,
    output logic                 o_qbit
);

    // One extra bit of headroom: the shifted remainder can reach 2*divisor-1.
    logic [DIVISOR_W:0] w_shifted;
    logic [DIVISOR_W:0] w_divisor_ext;
    logic [DIVISOR_W:0] w_diff;
    logic               w_fits;

    assign w_shifted     = {i_rem, i_bit};
    assign w_divisor_ext = {1'b0, i_divisor};
    assign w_diff        = w_shifted - w_divisor_ext;
    assign w_fits        = (w_shifted >= w_divisor_ext);

    // Either result is below the divisor, so the top bit is always zero here.
    assign o_rem  = w_fits ? w_diff[DIVISOR_W-1:0] : w_shifted[DIVISOR_W-1:0];
    assign o_qbit = w_fits;

endmodule : qaoa_kernel_div_step

// File: rtl/qaoa_kernel_udiv_141ns_53ns.sv
// -----------------------------------------------------------------------------
// qaoa_kernel_udiv_141ns_53ns
//
// Iterative unsigned divider: DIVIDEND_W-bit dividend / DIVISOR_W-bit divisor,
// QUOT_W-bit quotient, one restoring step per enabled clock.
//
// Flow: IDLE -(accept)-> CHECK -> ITER (QUOT_W steps) -> DONE -(taken)-> IDLE
//       CHECK jumps straight to DONE on a zero divisor or a quotient overflow.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low
//   ce           clock enable; low freezes every register
//   in_valid     operands valid
//   in_ready     idle, operands can be accepted
//   dividend     unsigned dividend  [DIVIDEND_W-1:0]
//   divisor      unsigned divisor   [DIVISOR_W-1:0]
//   out_valid    result valid, held until out_ready
//   out_ready    consumer takes result
//   quotient     unsigned quotient  [QUOT_W-1:0]   (all ones on error)
//   remainder    unsigned remainder [DIVISOR_W-1:0] (zero on error)
//   div_by_zero  divisor was zero
//   overflow     true quotient does not fit in QUOT_W bits
// -----------------------------------------------------------------------------
module qaoa_kernel_udiv_141ns_53ns
    import qaoa_kernel_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W,
    parameter int QUOT_W     = DEF_QUOT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int               CNT_W     = cnt_width(QUOT_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(QUOT_W - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    div_state_e           r_state;
    logic [CNT_W-1:0]     r_cnt;
    // Partial remainder; during ITER it doubles as the final remainder.
    logic [DIVISOR_W-1:0] r_rem;
    // Shift register: unused dividend bits leave at the top while quotient
    // bits enter at the bottom, so after QUOT_W steps it holds the quotient.
    logic [QUOT_W-1:0]    r_quo;
    logic [DIVISOR_W-1:0] r_divisor;
    logic                 r_dbz;
    logic                 r_ovf;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    // The high slice of the dividend seeds the partial remainder. Because
    // DIVIDEND_W <= QUOT_W + DIVISOR_W it always fits in DIVISOR_W bits.
    logic [DIVISOR_W-1:0] w_dividend_hi;
    logic [QUOT_W-1:0]    w_dividend_lo;
    logic                 w_divisor_zero;
    logic                 w_quot_overflow;
    logic [DIVISOR_W-1:0] w_step_rem;
    logic                 w_step_qbit;

    assign w_dividend_hi = DIVISOR_W'(dividend >> QUOT_W);
    assign w_dividend_lo = QUOT_W'(dividend);

    // In CHECK, r_rem still holds dividend >> QUOT_W. If that is already
    // >= divisor the first quotient bit above QUOT_W would be set.
    assign w_divisor_zero  = (r_divisor == '0);
    assign w_quot_overflow = (r_rem >= r_divisor);

    qaoa_kernel_div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_quo[QUOT_W-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_qbit)
    );

    // ------------------------------------------------------------------
    // FSM and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_dbz     <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (ce) begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_rem     <= w_dividend_hi;
                        r_quo     <= w_dividend_lo;
                        r_divisor <= divisor;
                        r_dbz     <= 1'b0;
                        r_ovf     <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (w_divisor_zero) begin
                        r_quo   <= '1;
                        r_rem   <= '0;
                        r_dbz   <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_quot_overflow) begin
                        r_quo   <= '1;
                        r_rem   <= '0;
                        r_ovf   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_ITER;
                    end
                end

                ST_ITER: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[QUOT_W-2:0], w_step_qbit};
                    if (r_cnt == LAST_STEP) begin
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule : qaoa_kernel_udiv_141ns_53ns
